// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, reads a synchronous-read program ROM,
// and issues one instruction every three cycles to the downstream decoder.
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | rom_addr = PC, ROM read in flight
// LOAD  | rom_data valid, captured into IR at end of cycle
// EXEC  | instr_valid = 1, PC branches or advances at end of cycle
// HALT  | illegal opcode seen, core frozen until reset
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              OPR_W    = 11,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [4+OPR_W:0]   rom_data,
    input  logic               hold,
    input  logic               pc_load,
    output logic [4:0]         opcode,
    output logic [OPR_W-1:0]   operand,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               illegal
);

    localparam int IW = 5 + OPR_W;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]      state;
    logic [PC_W-1:0] pc_q;
    logic [IW-1:0]   ir;
    logic            illegal_q;

    logic            is_illegal;
    logic            is_jump;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pc_inc;

    assign opcode      = ir[IW-1:OPR_W];
    assign operand     = ir[OPR_W-1:0];
    assign instr_valid = (state == EXEC);
    assign pc          = pc_q;
    assign rom_addr    = pc_q;
    assign illegal     = illegal_q;

    assign is_illegal = (opcode > 5'd18);
    assign is_jump    = (opcode == 5'd10) || (opcode == 5'd11) || (opcode == 5'd12);
    assign pc_inc     = pc_q + PC_W'(1);

    // Jump target is truncated or zero-extended to the PC width.
    generate
        if (OPR_W >= PC_W) begin : g_tgt_trunc
            assign jump_target = operand[PC_W-1:0];
        end else begin : g_tgt_ext
            assign jump_target = {{(PC_W-OPR_W){1'b0}}, operand};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc_q      <= RESET_PC;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!hold) state <= LOAD;
                end
                LOAD: begin
                    if (!hold) begin
                        ir    <= rom_data;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!hold) begin
                        if (is_illegal) begin
                            // pc_load is X from the decoder here, so it is never looked at.
                            illegal_q <= 1'b1;
                            ir        <= '0;
                            state     <= HALT;
                        end else begin
                            pc_q  <= (is_jump && pc_load) ? jump_target : pc_inc;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    ir <= '0;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural ROM, opcode scoreboard checked on each
// EXEC, a table of single-instruction vectors and hand sequences for hold/reset/halt.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        pc_load;
    logic        pl_drive = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [4:0]  opcode;
    logic [10:0] operand;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        illegal;

    logic [15:0] mem [256];
    logic [15:0] sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
        logic        pl;
        logic [7:0]  nxt;
        logic        ill;
    } vec_t;

    vec_t       vt [16];
    logic [7:0] exp_addr [9];
    logic [4:0] exp_op [9];

    fetch_unit #(.PC_W(8), .OPR_W(11), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .hold        (hold),
        .pc_load     (pc_load),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .pc          (pc),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    always_comb pc_load = pl_drive;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opr);
        return {op, opr};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        hold     = 1'b0;
        pl_drive = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_exec(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(posedge clk);
            #1;
            if (instr_valid) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no instr_valid expected instr_valid within 12 cycles", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{8'h05, ins(5'd10, 11'h040), 1'b1, 8'h40, 1'b0};
        vt[1]  = '{8'h05, ins(5'd10, 11'h040), 1'b0, 8'h06, 1'b0};
        vt[2]  = '{8'h20, ins(5'd11, 11'h033), 1'b1, 8'h33, 1'b0};
        vt[3]  = '{8'h20, ins(5'd11, 11'h033), 1'b0, 8'h21, 1'b0};
        vt[4]  = '{8'h20, ins(5'd12, 11'h055), 1'b1, 8'h55, 1'b0};
        vt[5]  = '{8'h20, ins(5'd12, 11'h055), 1'b0, 8'h21, 1'b0};
        vt[6]  = '{8'h07, ins(5'd3,  11'h010), 1'b1, 8'h08, 1'b0};
        vt[7]  = '{8'h07, ins(5'd3,  11'h010), 1'bx, 8'h08, 1'b0};
        vt[8]  = '{8'hFF, ins(5'd0,  11'h000), 1'b0, 8'h00, 1'b0};
        vt[9]  = '{8'h05, ins(5'd10, 11'h7FF), 1'b1, 8'hFF, 1'b0};
        vt[10] = '{8'h30, ins(5'd18, 11'h0AB), 1'b1, 8'h31, 1'b0};
        vt[11] = '{8'h30, ins(5'd13, 11'h0AB), 1'b1, 8'h31, 1'b0};
        vt[12] = '{8'h30, ins(5'd9,  11'h0AB), 1'b1, 8'h31, 1'b0};
        vt[13] = '{8'h10, ins(5'd19, 11'h0AB), 1'b1, 8'h10, 1'b1};
        vt[14] = '{8'h11, ins(5'd31, 11'h7FF), 1'b0, 8'h11, 1'b1};
        vt[15] = '{8'h20, ins(5'd12, 11'h1AB), 1'b1, 8'hAB, 1'b0};
        exp_addr = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
        exp_op   = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd3, 5'd3, 5'd3, 5'd0};

        // Scoreboard monitor: compare IR against the queued word on each EXEC entry.
        fork
            begin
                bit          iv_prev;
                logic [15:0] e;
                iv_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst_n && instr_valid && !iv_prev) begin
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL sb_underflow: got opcode %0d with empty queue expected no instruction", opcode);
                        end else begin
                            e = sb.pop_front();
                            chk("sb_instr", {opcode, operand}, e);
                        end
                    end
                    iv_prev = instr_valid;
                end
            end
        join_none

        // Reset values and the basic three-cycle cadence.
        clear_mem();
        mem[0] = ins(5'd1, 11'd1);
        mem[1] = ins(5'd3, 11'd2);
        mem[2] = ins(5'd0, 11'd0);
        #1;
        chk("rst_valid",   instr_valid, 1'b0);
        chk("rst_opcode",  opcode, 5'd0);
        chk("rst_operand", operand, 11'd0);
        chk("rst_addr",    rom_addr, 8'h00);
        chk("rst_pc",      pc, 8'h00);
        chk("rst_illegal", illegal, 1'b0);
        sb.push_back(mem[0]);
        sb.push_back(mem[1]);
        sb.push_back(mem[2]);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("cad%0d_addr", c), rom_addr, exp_addr[c-1]);
            chk($sformatf("cad%0d_valid", c), instr_valid, (c % 3) == 0);
            if ((c % 3) == 0) chk($sformatf("cad%0d_op", c), opcode, exp_op[c-1]);
        end

        // Single-instruction vectors, each reached through a jump from address 0.
        for (int i = 0; i < 16; i++) begin
            clear_mem();
            mem[0] = {5'd10, 3'b000, vt[i].addr};
            mem[vt[i].addr] = vt[i].word;
            do_reset();
            sb.push_back(mem[0]);
            sb.push_back(vt[i].word);
            pl_drive = 1'b1;
            wait_exec($sformatf("v%0d_jmp", i));
            step();
            pl_drive = vt[i].pl;
            wait_exec($sformatf("v%0d_ins", i));
            step();
            chk($sformatf("v%0d_next", i), rom_addr, vt[i].nxt);
            chk($sformatf("v%0d_illegal", i), illegal, vt[i].ill);
            chk($sformatf("v%0d_valid", i), instr_valid, 1'b0);
        end

        // Hold during LOAD: IR gets the right word and cadence resumes.
        clear_mem();
        mem[0] = ins(5'd1, 11'h055);
        mem[1] = ins(5'd3, 11'h066);
        do_reset();
        sb.push_back(mem[0]);
        sb.push_back(mem[1]);
        step();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hl_valid", instr_valid, 1'b0);
            chk("hl_addr", rom_addr, 8'h00);
        end
        hold = 1'b0;
        step();
        chk("hl_exec", instr_valid, 1'b1);
        chk("hl_operand", operand, 11'h055);
        step();
        chk("hl_next_addr", rom_addr, 8'h01);
        step();
        step();
        chk("hl_cadence", instr_valid, 1'b1);
        step();

        // Hold during EXEC: instr_valid stretched, PC advances once.
        clear_mem();
        mem[0] = ins(5'd3, 11'h007);
        do_reset();
        sb.push_back(mem[0]);
        sb.push_back(mem[1]);
        wait_exec("he_first");
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("he_valid", instr_valid, 1'b1);
            chk("he_addr", rom_addr, 8'h00);
            step();
        end
        hold = 1'b0;
        step();
        chk("he_after_valid", instr_valid, 1'b0);
        chk("he_after_addr", rom_addr, 8'h01);
        wait_exec("he_second");
        step();
        chk("he_second_addr", rom_addr, 8'h02);

        // Reset asserted mid-LOAD clears outputs without a clock edge.
        clear_mem();
        mem[0] = ins(5'd1, 11'h001);
        do_reset();
        sb.push_back(mem[0]);
        wait_exec("rl_exec");
        step();
        @(posedge clk);
        #3;
        chk("rl_pre_opcode", opcode, 5'd1);
        chk("rl_pre_pc", pc, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rl_opcode", opcode, 5'd0);
        chk("rl_operand", operand, 11'd0);
        chk("rl_valid", instr_valid, 1'b0);
        chk("rl_addr", rom_addr, 8'h00);
        chk("rl_pc", pc, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Illegal opcode 25 at address 9: halt, hold ignored, reset recovers.
        clear_mem();
        mem[0] = ins(5'd10, 11'h009);
        mem[9] = ins(5'd25, 11'h123);
        do_reset();
        sb.push_back(mem[0]);
        sb.push_back(mem[9]);
        pl_drive = 1'b1;
        wait_exec("il_jmp");
        step();
        pl_drive = 1'bx;
        wait_exec("il_ins");
        chk("il_pre_flag", illegal, 1'b0);
        step();
        chk("il_flag", illegal, 1'b1);
        chk("il_pc", pc, 8'h09);
        chk("il_valid", instr_valid, 1'b0);
        chk("il_ir_nop", opcode, 5'd0);
        for (int i = 0; i < 6; i++) begin
            hold = ~hold;
            step();
            chk("il_halt_valid", instr_valid, 1'b0);
            chk("il_halt_pc", pc, 8'h09);
            chk("il_halt_flag", illegal, 1'b1);
        end
        hold = 1'b0;
        pl_drive = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("il_rst_flag", illegal, 1'b0);
        chk("il_rst_pc", pc, 8'h00);
        step();
        rst_n = 1'b1;
        step();

        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
